seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse operation of the team's combinational 8-bit-product multiplier.
- Takes an 8-bit dividend (product width) and a 4-bit divisor (operand width). Returns quotient and remainder.
- Dividing a multiplier product by one of its operands recovers the other operand.
- Sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake.

---
 rtl/arith_pkg.sv | 17 +
 rtl/seq_divider_if.sv | 32 +++
 rtl/seq_divider_step.sv | 48 ++++
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
//   DEF_DW / DEF_VW : default dividend (product) and divisor (operand) widths
//   DEF_CW          : bit-counter width for the default dividend width
//   state_t         : sequential divider FSM state encoding
package arith_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_VW = 4;
    localparam int DEF_CW = $clog2(DEF_DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for the sequential divider.
//   start, dividend, divisor            : requester -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                         : divider -> requester
// Modport master is the requesting side, slave is the divider.
interface seq_divider_if
    import arith_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) ();

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration.
//   pr      in  VW  current partial remainder (its top bit is always 0, so
//                   only the low VW bits are carried)
//   bit_in  in  1   next dividend bit, MSB first
//   divisor in  VW  denominator
//   pr_next out VW  partial remainder after this iteration
//   qbit    out 1   quotient bit produced by this iteration
// The compare and subtract share one VW+1-bit ripple-borrow chain: the
// final borrow out is the "t < divisor" decision.
module div_step
    import arith_pkg::*;
#(
    parameter int VW = DEF_VW
) (
    input  logic [VW-1:0] pr,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] pr_next,
    output logic          qbit
);

    logic [VW:0]   t;
    logic [VW:0]   d;
    logic [VW+1:0] borrow;
    logic [VW-1:0] diff;

    assign t         = {pr, bit_in};
    assign d         = {1'b0, divisor};
    assign borrow[0] = 1'b0;

    // Full-subtractor borrow chain over all VW+1 bits.
    generate
        for (genvar gi = 0; gi < VW + 1; gi++) begin : g_borrow
            assign borrow[gi+1] = (~t[gi] & d[gi]) | (~(t[gi] ^ d[gi]) & borrow[gi]);
        end
        // The top difference bit is never needed: when t >= divisor the
        // result is below the divisor and therefore fits in VW bits.
        for (genvar gi = 0; gi < VW; gi++) begin : g_diff
            assign diff[gi] = t[gi] ^ d[gi] ^ borrow[gi];
        end
    endgenerate

    // No borrow out of the chain means t >= divisor.
    assign qbit    = ~borrow[VW+1];
    // When qbit=0, t < divisor <= 2**VW-1 so t[VW] is 0 and the low bits suffice.
    assign pr_next = qbit ? diff : t[VW-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of seq_divider_if:
//          start/dividend/divisor in; busy/done/quotient/remainder/
//          div_by_zero out
// One quotient bit is produced per cycle, MSB first; done pulses DW+1
// cycles after an accepted start (1 cycle for a zero divisor).
module seq_divider
    import arith_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider_if.slave   bus
);

    localparam int CW = $clog2(DW);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] dvd_q,   dvd_d;
    logic [VW-1:0] dvs_q,   dvs_d;
    logic [VW-1:0] pr_q,    pr_d;
    logic [DW-1:0] quot_q,  quot_d;
    logic          dbz_q,   dbz_d;

    logic          accept;
    logic          div_zero;
    logic [VW-1:0] step_pr;
    logic          step_qbit;

    // A request is taken whenever no iteration is in flight, which
    // includes the DONE cycle so operations can run back to back.
    assign accept   = bus.start && (state_q != RUN);
    assign div_zero = (bus.divisor == '0);

    div_step #(.VW(VW)) u_step (
        .pr      (pr_q),
        .bit_in  (dvd_q[DW-1]),
        .divisor (dvs_q),
        .pr_next (step_pr),
        .qbit    (step_qbit)
    );

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quot_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quot_q  <= quot_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = div_zero ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, iterate while running.
    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        pr_d   = pr_q;
        quot_d = quot_q;
        dbz_d  = dbz_q;
        if (accept) begin
            cnt_d = CW'(DW - 1);
            dvd_d = bus.dividend;
            dvs_d = bus.divisor;
            dbz_d = div_zero;
            if (div_zero) begin
                // Zero divisor: saturated quotient, low dividend bits as remainder.
                quot_d = '1;
                pr_d   = bus.dividend[VW-1:0];
            end else begin
                quot_d = '0;
                pr_d   = '0;
            end
        end else if (state_q == RUN) begin
            cnt_d  = cnt_q - 1'b1;
            dvd_d  = {dvd_q[DW-2:0], 1'b0};
            pr_d   = step_pr;
            quot_d = {quot_q[DW-2:0], step_qbit};
        end
    end

    // Output logic.
    always_comb begin
        bus.busy        = (state_q == RUN);
        bus.done        = (state_q == DONE);
        bus.quotient    = quot_q;
        bus.remainder   = pr_q;
        bus.div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios, random
// operations and an exhaustive nonzero-divisor sweep, all checked against
// a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;
    localparam int LAT = DW + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    seq_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issues one operation from the current cycle and returns in its done cycle.
    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int lat;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic ez;
        int exp_lat;
        if (b == 0) begin
            eq = '1; er = a[VW-1:0]; ez = 1'b1; exp_lat = 1;
        end else begin
            eq = DW'(int'(a) / int'(b));
            er = VW'(int'(a) % int'(b));
            ez = 1'b0; exp_lat = LAT;
        end
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        tick();
        bus.start = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor = VW'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 30) begin
            total++;
            if (bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_run %0d/%0d cyc%0d got=%b want=1", a, b, lat, bus.busy);
            end
            tick();
            lat++;
        end
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL latency %0d/%0d got=%0d want=%0d", a, b, lat, exp_lat);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_done %0d/%0d got=%b want=0", a, b, bus.busy);
        end
        total++;
        if (bus.quotient !== eq) begin
            bad++;
            $display("FAIL quotient %0d/%0d got=%0d want=%0d", a, b, bus.quotient, eq);
        end
        total++;
        if (bus.remainder !== er) begin
            bad++;
            $display("FAIL remainder %0d/%0d got=%0d want=%0d", a, b, bus.remainder, er);
        end
        total++;
        if (bus.div_by_zero !== ez) begin
            bad++;
            $display("FAIL dbz %0d/%0d got=%b want=%b", a, b, bus.div_by_zero, ez);
        end
        $display("op %0d/%0d -> q=%0d r=%0d dbz=%b lat=%0d", a, b,
                 bus.quotient, bus.remainder, bus.div_by_zero, lat);
    endtask

    task automatic check_zero_outputs(input string tag);
        total++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            bad++;
            $display("FAIL %s busy=%b done=%b q=%0d r=%0d dbz=%b want all 0", tag,
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        tick(); tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_zero_outputs("idle_after_reset");
        $display("reset checked");
    endtask

    task automatic test_basic();
        run_op(8'd143, 4'd11);
        idle(1);
    endtask

    task automatic test_back_to_back();
        run_op(8'd200, 4'd7);
        run_op(8'd255, 4'd1);
        run_op(8'd5, 4'd9);
        idle(1);
    endtask

    task automatic test_div_zero();
        run_op(8'hA6, 4'd0);
        run_op(8'h10, 4'd4);
        idle(1);
    endtask

    task automatic test_hold();
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        run_op(8'd77, 4'd6);
        q = 8'd12; r = 4'd5;
        idle(3);
        total++;
        if (bus.done !== 1'b0 || bus.quotient !== q || bus.remainder !== r) begin
            bad++;
            $display("FAIL hold done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
                     bus.done, bus.quotient, bus.remainder, q, r);
        end
        $display("hold q=%0d r=%0d", bus.quotient, bus.remainder);
    endtask

    task automatic test_start_ignored();
        int lat;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd3;
        tick();
        lat = 1;
        while (bus.done !== 1'b1 && lat < 30) begin
            if (lat == 4) begin
                bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        total++;
        if (lat != LAT || bus.quotient !== 8'd33 || bus.remainder !== 4'd1) begin
            bad++;
            $display("FAIL ignore_start lat=%0d q=%0d r=%0d want lat=%0d q=33 r=1",
                     lat, bus.quotient, bus.remainder, LAT);
        end
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_second done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        $display("op 100/3 with stray start -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);
    endtask

    task automatic test_reset_mid();
        int seen_done;
        bus.start = 1'b1; bus.dividend = 8'd240; bus.divisor = 4'd15;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero_outputs("mid_reset");
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) seen_done++;
            tick();
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL mid_reset_done got=%0d pulses want=0", seen_done);
        end
        $display("mid-op reset, done pulses after=%0d", seen_done);
        run_op(8'd240, 4'd15);
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(DW'($urandom), VW'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);
    endtask

    task automatic test_sweep();
        for (int d = 1; d < 16; d++) begin
            for (int a = 0; a < 256; a++) begin
                run_op(DW'(a), VW'(d));
                total++;
                if (int'(bus.quotient) * d + int'(bus.remainder) != a ||
                    int'(bus.remainder) >= d) begin
                    bad++;
                    $display("FAIL sweep_identity %0d/%0d q=%0d r=%0d", a, d,
                             bus.quotient, bus.remainder);
                end
            end
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_hold();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
